// File: rtl/mpu6050_pkg.sv
// Shared constants and state encoding for the MPU6050 burst reader.
package mpu6050_pkg;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] TEMP_OUT_H   = 8'h41;
    localparam logic [7:0] GYRO_XOUT_H  = 8'h43;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StStore,
        StCommit
    } state_e;

endpackage

// File: rtl/mpu6050_data_reader_if.sv
// Request, byte-read handshake and frame result signals of the MPU6050 reader.
interface mpu6050_data_reader_if;

    logic        ReadReq;
    logic [7:0]  RegAddr;
    logic        RdReq;
    logic        RdDone;
    logic [7:0]  RdData;
    logic [15:0] AccX;
    logic [15:0] AccY;
    logic [15:0] AccZ;
    logic [15:0] Temp;
    logic [15:0] GyroX;
    logic [15:0] GyroY;
    logic [15:0] GyroZ;
    logic        DataValid;
    logic        Busy;
    logic        Timeout;

    modport slave (
        input  ReadReq, RdDone, RdData,
        output RegAddr, RdReq, AccX, AccY, AccZ, Temp, GyroX, GyroY, GyroZ,
        output DataValid, Busy, Timeout
    );

    modport master (
        output ReadReq, RdDone, RdData,
        input  RegAddr, RdReq, AccX, AccY, AccZ, Temp, GyroX, GyroY, GyroZ,
        input  DataValid, Busy, Timeout
    );

endinterface

// File: rtl/mpu6050_data_reader.sv
// Reads one sensor frame byte by byte through a bus master and publishes all
// seven 16-bit values at once, aborting the frame if a byte never arrives.
module mpu6050_data_reader
    import mpu6050_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = ACCEL_XOUT_H,
    parameter int unsigned NUM_BYTES   = 14,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input logic                   clk,
    input logic                   rst,
    mpu6050_data_reader_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

    state_e          state;
    logic [IdxW-1:0] idx;
    logic [15:0]     wait_cnt;
    logic [7:0]      buffer [NUM_BYTES];

    assign bus.Busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            idx           <= '0;
            wait_cnt      <= '0;
            buffer        <= '{default: '0};
            bus.RegAddr   <= '0;
            bus.RdReq     <= 1'b0;
            bus.AccX      <= '0;
            bus.AccY      <= '0;
            bus.AccZ      <= '0;
            bus.Temp      <= '0;
            bus.GyroX     <= '0;
            bus.GyroY     <= '0;
            bus.GyroZ     <= '0;
            bus.DataValid <= 1'b0;
            bus.Timeout   <= 1'b0;
        end else begin
            bus.DataValid <= 1'b0;
            bus.Timeout   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.ReadReq) begin
                        idx   <= '0;
                        state <= StReq;
                    end
                end
                StReq: begin
                    bus.RegAddr <= BASE_ADDR + 8'(idx);
                    bus.RdReq   <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= StWait;
                end
                StWait: begin
                    // A byte landing on the expiry cycle still counts.
                    if (bus.RdDone) begin
                        buffer[idx] <= bus.RdData;
                        bus.RdReq   <= 1'b0;
                        state       <= StStore;
                    end else if (wait_cnt == TIMEOUT_CYC - 16'd1) begin
                        bus.Timeout <= 1'b1;
                        bus.RdReq   <= 1'b0;
                        state       <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                StStore: begin
                    if (idx == LastIdx) begin
                        state <= StCommit;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= StReq;
                    end
                end
                StCommit: begin
                    bus.AccX      <= {buffer[0],  buffer[1]};
                    bus.AccY      <= {buffer[2],  buffer[3]};
                    bus.AccZ      <= {buffer[4],  buffer[5]};
                    bus.Temp      <= {buffer[6],  buffer[7]};
                    bus.GyroX     <= {buffer[8],  buffer[9]};
                    bus.GyroY     <= {buffer[10], buffer[11]};
                    bus.GyroZ     <= {buffer[12], buffer[13]};
                    bus.DataValid <= 1'b1;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
